simple_add_example_xfer_issuer: RTL and testbench
=================================================

SIMPLE_ADD_EXAMPLE_XFER_ISSUER -- requirements
Module: simple_add_example_xfer_issuer

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 64, byte-address width.
REQ-002 SHALL have parameter C_LEN_WIDTH, default 32, width of the total beat count.
REQ-003 SHALL have parameter C_MAX_BEATS, default 64, beats per burst; power of 2, 1..256.
REQ-004 SHALL have parameter C_BYTES_PER_BEAT, default 64, bytes per beat; power of 2; C_MAX_BEATS*C_BYTES_PER_BEAT <= 4096.
REQ-005 SHALL have parameter C_MAX_OUTSTANDING, default 16, maximum bursts in flight; 1..255.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, single-cycle request to begin a transfer.
REQ-009 SHALL have port base_addr, input, C_ADDR_WIDTH, start byte address, aligned to C_MAX_BEATS*C_BYTES_PER_BEAT.
REQ-010 SHALL have port num_beats, input, C_LEN_WIDTH, total beats to request.
REQ-011 SHALL have port busy, output, 1, high from an accepted start until the done cycle inclusive.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port req_valid, input req_ready, output req_addr (C_ADDR_WIDTH), and output req_len (8, beats-1), forming the burst request channel.
REQ-014 SHALL have port cpl, input, 1, one pulse per completed burst.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE: start latches base_addr and num_beats; nonzero num_beats -> ISSUE, zero -> DONE.
REQ-017 start SHALL be ignored in every state except IDLE.
REQ-018 ISSUE: req_valid SHALL be high when outstanding < C_MAX_OUTSTANDING.
REQ-019 Burst length SHALL be min(remaining, C_MAX_BEATS); req_len SHALL be that length minus 1.
REQ-020 Handshake (req_valid & req_ready): req_addr SHALL advance by length*C_BYTES_PER_BEAT, remaining SHALL decrease by length, and outstanding SHALL be incremented.
REQ-021 Once asserted, req_valid, req_addr, and req_len SHALL be held stable until the handshake completes.
REQ-022 The handshake that sets remaining to 0 SHALL move the FSM to DRAIN; req_valid SHALL be low in DRAIN, DONE, and IDLE.
REQ-023 cpl SHALL decrement outstanding; a cpl coincident with a handshake SHALL leave outstanding unchanged.
REQ-024 cpl with outstanding == 0 SHALL be ignored; outstanding SHALL NOT wrap.
REQ-025 DRAIN -> DONE in the cycle after outstanding reaches 0 (including the cycle a final cpl makes it 0).
REQ-026 DONE SHALL assert done for exactly one cycle and then return to IDLE; a new start is accepted the following cycle.
REQ-027 The first req_valid SHALL appear one cycle after start; zero-length done SHALL appear two cycles after start.

Reset
REQ-028 rst SHALL force IDLE, with busy=0, done=0, req_valid=0, req_addr=0, req_len=0, outstanding=0, and remaining=0.
REQ-029 rst mid-transfer SHALL abandon the transfer with no done pulse; any later cpl SHALL be ignored per REQ-024.

Structure
REQ-030 The FSM state enum and the burst-length width constant (8) SHALL reside in package simple_add_example_pkg.
REQ-031 The outstanding count SHALL use one simple_add_example_counter instance: incr=handshake, decr=cpl gated by nonzero, rst=rst.
REQ-032 The remaining and address registers SHALL be local to the module.

Verification (C_MAX_BEATS=64, C_BYTES_PER_BEAT=64, C_MAX_OUTSTANDING=4)
REQ-033 num_beats=130, base 0x1000, req_ready=1, cpl 3 cycles after each handshake -> requests (0x1000,63), (0x2000,63), (0x3000,1); done once, one cycle after the third cpl is counted.
REQ-034 num_beats=384, no cpl -> exactly 4 handshakes, then req_valid low; a single cpl -> 5th request (addr base+0x4000) issued the next cycle.
REQ-035 req_ready low for 5 cycles while req_valid=1 -> req_valid, req_addr, and req_len stable all 5 cycles.
REQ-036 num_beats=0 -> no req_valid; busy high for 2 cycles; done pulse in the cycle 2 after start.
REQ-037 outstanding=2 with cpl and handshake in the same cycle -> outstanding stays 2; a stray cpl in IDLE -> outstanding stays 0.
REQ-038 rst in ISSUE after 2 handshakes -> next cycle req_valid=0, busy=0, no done; a subsequent start behaves as from power-up.

Source files
------------

// File: rtl/simple_add_example_pkg.sv
// Shared types and constants for the simple_add_example burst issuer slice.
package simple_add_example_pkg;

    localparam int BURST_LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/simple_add_example_counter.sv
// Up/down occupancy counter; simultaneous incr and decr cancel out.
module simple_add_example_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         incr,
    input  logic         decr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (incr && !decr) begin
            count <= count + W'(1);
        end else if (decr && !incr) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/simple_add_example_xfer_issuer.sv
// Splits a beat-count transfer into aligned bursts, bounding bursts in flight
// and pulsing done once every issued burst has completed.
module simple_add_example_xfer_issuer
    import simple_add_example_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_LEN_WIDTH       = 32,
    parameter int C_MAX_BEATS       = 64,
    parameter int C_BYTES_PER_BEAT  = 64,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [C_ADDR_WIDTH-1:0] base_addr,
    input  logic [C_LEN_WIDTH-1:0]  num_beats,
    output logic                    busy,
    output logic                    done,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [C_ADDR_WIDTH-1:0] req_addr,
    output logic [BURST_LEN_W-1:0]  req_len,
    input  logic                    cpl
);

    localparam int OUT_W     = 8;
    localparam int BEAT_W    = BURST_LEN_W + 1;
    localparam int BPB_SHIFT = $clog2(C_BYTES_PER_BEAT);

    xfer_state_e              state, state_nxt;
    logic [C_LEN_WIDTH-1:0]   remaining;
    logic [C_LEN_WIDTH-1:0]   remaining_nxt;
    logic [OUT_W-1:0]         outstanding;
    logic [BEAT_W-1:0]        cur_beats;
    logic                     done_r;
    logic                     accept;
    logic                     hs;
    logic                     cpl_eff;

    function automatic logic [BEAT_W-1:0] sat_beats(input logic [C_LEN_WIDTH-1:0] r);
        if (r >= C_LEN_WIDTH'(C_MAX_BEATS)) return BEAT_W'(C_MAX_BEATS);
        return BEAT_W'(r);
    endfunction

    function automatic logic [BURST_LEN_W-1:0] len_field(input logic [BEAT_W-1:0] b);
        if (b == '0) return '0;
        return BURST_LEN_W'(b - BEAT_W'(1));
    endfunction

    // done is registered, so the done cycle is the one after DONE; a start
    // arriving during that cycle is still part of the finishing transfer.
    assign accept        = start && (state == IDLE) && !done_r;
    assign hs            = req_valid && req_ready;
    assign cpl_eff       = cpl && (outstanding != '0);
    assign cur_beats     = sat_beats(remaining);
    assign remaining_nxt = remaining - C_LEN_WIDTH'(cur_beats);
    assign busy          = (state != IDLE) || done_r;
    assign done          = done_r;

    simple_add_example_counter #(
        .W(OUT_W)
    ) u_outstanding (
        .clk  (clk),
        .rst  (rst),
        .incr (hs),
        .decr (cpl_eff),
        .count(outstanding)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (num_beats != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
                req_valid = (outstanding < OUT_W'(C_MAX_OUTSTANDING));
                if (req_valid && req_ready && (remaining_nxt == '0)) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Leave as soon as the count is, or is about to become, zero.
                if ((outstanding == '0) || ((outstanding == OUT_W'(1)) && cpl)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            req_addr  <= '0;
            req_len   <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= (state == DONE);
            if (accept) begin
                remaining <= num_beats;
                req_addr  <= base_addr;
                req_len   <= len_field(sat_beats(num_beats));
            end else if (hs) begin
                remaining <= remaining_nxt;
                req_addr  <= req_addr + (C_ADDR_WIDTH'(cur_beats) << BPB_SHIFT);
                req_len   <= len_field(sat_beats(remaining_nxt));
            end
        end
    end

endmodule

// File: tb/tb_simple_add_example_xfer_issuer.sv
// Directed bench for the burst issuer: reset, zero-length, split, throttle,
// stall, coincident cpl/handshake and mid-transfer reset.
module tb_simple_add_example_xfer_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] base_addr;
    logic [31:0] num_beats;
    logic        busy;
    logic        done;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [7:0]  req_len;
    logic        cpl;

    int n_vec = 0;
    int n_err = 0;
    int nhs;
    int ndone;
    int done_at;
    int hs_at [8];
    logic [63:0] exp_addr [3];
    logic [7:0]  exp_len  [3];

    simple_add_example_xfer_issuer #(
        .C_ADDR_WIDTH     (64),
        .C_LEN_WIDTH      (32),
        .C_MAX_BEATS      (64),
        .C_BYTES_PER_BEAT (64),
        .C_MAX_OUTSTANDING(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .num_beats(num_beats),
        .busy     (busy),
        .done     (done),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_len  (req_len),
        .cpl      (cpl)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_beats = '0;
        req_ready = 1'b0; cpl = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", req_valid, 0);
        chk("rst_addr", req_addr, 0);
        chk("rst_len", req_len, 0);
        chk("rst_outstanding", dut.outstanding, 0);
        rst = 1'b0;
        cycle();

        // Zero-length transfer
        start = 1'b1; num_beats = 0; base_addr = 64'h5000;
        cycle();
        start = 1'b0;
        chk("zl_busy_c1", busy, 1);
        chk("zl_done_c1", done, 0);
        chk("zl_valid_c1", req_valid, 0);
        cycle();
        chk("zl_busy_c2", busy, 1);
        chk("zl_done_c2", done, 1);
        chk("zl_valid_c2", req_valid, 0);
        cycle();
        chk("zl_busy_c3", busy, 0);
        chk("zl_done_c3", done, 0);

        // 130 beats split into 64/64/2, completions three cycles after each handshake
        exp_addr[0] = 64'h1000; exp_len[0] = 8'd63;
        exp_addr[1] = 64'h2000; exp_len[1] = 8'd63;
        exp_addr[2] = 64'h3000; exp_len[2] = 8'd1;
        start = 1'b1; num_beats = 130; base_addr = 64'h1000; req_ready = 1'b1;
        nhs = 0; ndone = 0; done_at = -1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) start = 1'b0;
            cpl = 1'b0;
            for (int h = 0; h < nhs; h++) if (c == hs_at[h] + 3) cpl = 1'b1;
            if (c == 1) chk("split_first_valid", req_valid, 1);
            if (req_valid && req_ready) begin
                if (nhs < 3) begin
                    chk($sformatf("split_addr%0d", nhs), req_addr, exp_addr[nhs]);
                    chk($sformatf("split_len%0d", nhs), req_len, exp_len[nhs]);
                    hs_at[nhs] = c;
                end else begin
                    chk("split_extra_hs", nhs, 3);
                end
                nhs++;
            end
            if (done) begin ndone++; done_at = c; end
            cycle();
        end
        cpl = 1'b0;
        chk("split_hs_count", nhs, 3);
        chk("split_done_count", ndone, 1);
        chk("split_done_cycle", done_at, 8);
        chk("split_busy_after", busy, 0);

        // 384 beats, no completions: throttled at four in flight
        start = 1'b1; num_beats = 384; base_addr = 64'h10000; req_ready = 1'b1;
        nhs = 0;
        for (int c = 0; c < 8; c++) begin
            if (req_valid && req_ready) nhs++;
            cycle();
            start = 1'b0;
        end
        chk("thr_hs_count", nhs, 4);
        chk("thr_valid_low", req_valid, 0);
        chk("thr_outstanding", dut.outstanding, 4);
        cpl = 1'b1;
        cycle();
        cpl = 1'b0;
        chk("thr_5th_valid", req_valid, 1);
        chk("thr_5th_addr", req_addr, 64'h14000);
        chk("thr_5th_len", req_len, 63);
        req_ready = 1'b0;

        // Stall with ready low; a start here must not disturb the request
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            base_addr = 64'hDEAD000; num_beats = 5;
            chk($sformatf("stall_valid%0d", i), req_valid, 1);
            chk($sformatf("stall_addr%0d", i), req_addr, 64'h14000);
            chk($sformatf("stall_len%0d", i), req_len, 63);
            cycle();
        end
        start = 1'b0;
        chk("stall_busy", busy, 1);

        // Coincident cpl and handshake at two outstanding
        cpl = 1'b1;
        cycle();
        chk("coin_pre_outstanding", dut.outstanding, 2);
        req_ready = 1'b1;
        cycle();
        chk("coin_outstanding", dut.outstanding, 2);
        chk("coin_6th_valid", req_valid, 1);
        chk("coin_6th_addr", req_addr, 64'h15000);
        chk("coin_6th_len", req_len, 63);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            cycle();
        end
        chk("thr_done_count", ndone, 1);
        chk("idle_stray_cpl_outstanding", dut.outstanding, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", req_valid, 0);
        cpl = 1'b0; req_ready = 1'b1;

        // Reset in ISSUE after two handshakes
        start = 1'b1; num_beats = 384; base_addr = 64'h20000;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        chk("mid_outstanding_pre", dut.outstanding, 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_valid", req_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_outstanding", dut.outstanding, 0);
        ndone = 0;
        cpl = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (done) ndone++;
            cycle();
        end
        cpl = 1'b0;
        chk("mid_no_done", ndone, 0);
        chk("mid_cpl_ignored", dut.outstanding, 0);

        // Fresh single-beat transfer after the abandoned one
        start = 1'b1; num_beats = 1; base_addr = 64'h3000; req_ready = 1'b0;
        cycle();
        start = 1'b0;
        chk("post_valid", req_valid, 1);
        chk("post_addr", req_addr, 64'h3000);
        chk("post_len", req_len, 0);
        chk("post_busy", busy, 1);
        req_ready = 1'b1; cpl = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            cycle();
        end
        chk("post_done_count", ndone, 1);
        chk("post_busy_end", busy, 0);
        cpl = 1'b0; req_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
